eth_pixel_write_ctrl: RTL and testbench

- Sequences writes into the 320x240x8 frame buffer from the filtered Ethernet payload stream (firewall output, 2-bit dibits, MSB pair first).
- Assembles dibits into bytes and parses a 2-byte row header.
- Generates frame-buffer address, data and write strobe, and flags frame completion.
- Counts CRC-good and CRC-bad packets from the checksum block's done/kill verdicts.
- Sits between firewall/cksum and write port A of the frame buffer, all in the 50 MHz Ethernet clock domain.

---
 rtl/eth_pixel_write_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_eth_pixel_write_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pixel_write_ctrl.sv
// Frame-buffer write sequencer for the filtered Ethernet pixel stream.
// Parses a 2-byte row header, emits pixel writes and counts CRC verdicts.
module eth_pixel_write_ctrl #(
  parameter int H_PIXELS   = 320,
  parameter int V_PIXELS   = 240,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  axiiv,
  input  logic [1:0]            axiid,
  input  logic                  crc_done,
  input  logic                  crc_kill,
  output logic [ADDR_WIDTH-1:0] pixel_addr_out,
  output logic [7:0]            pixel_out,
  output logic                  pixel_valid_out,
  output logic                  frame_done_out,
  output logic [15:0]           good_pkt_count,
  output logic [15:0]           bad_pkt_count,
  output logic [15:0]           bad_hdr_count
);

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_PIXELS,
    S_DRAIN
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LP_COL_LAST =
    ADDR_WIDTH'(H_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] LP_ADDR_LAST =
    ADDR_WIDTH'(H_PIXELS * V_PIXELS - 1);
  localparam logic [15:0] LP_ROWS = 16'(V_PIXELS);
  localparam logic [15:0] LP_SAT  = 16'hFFFF;

  state_t                r_state;
  state_t                w_state_n;
  logic [1:0]            r_dcnt;
  logic [5:0]            r_shift;
  logic [7:0]            r_row_hi;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_col;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_pix;
  logic                  r_pv;
  logic                  r_fd;
  logic [15:0]           r_good;
  logic [15:0]           r_bad;
  logic [15:0]           r_bhdr;

  logic                  w_byte_done;
  logic [7:0]            w_byte;
  logic [15:0]           w_row;
  logic [ADDR_WIDTH-1:0] w_row_base;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_write;
  logic                  w_hdr_bad;
  logic                  w_load_base;

  assign w_byte      = {r_shift, axiid};
  assign w_byte_done = axiiv && (r_dcnt == 2'd3);
  assign w_row       = {r_row_hi, w_byte};
  assign w_addr      = r_base + r_col;

  // Row base address; the default width uses 256+64 shifts
  generate
    if (H_PIXELS == 320) begin : g_shift
      assign w_row_base = ADDR_WIDTH'(
        ({16'b0, w_row} << 8) + ({16'b0, w_row} << 6));
    end else begin : g_mult
      assign w_row_base = ADDR_WIDTH'(
        {16'b0, w_row} * 32'(H_PIXELS));
    end
  endgenerate

  // Dibit assembler: cleared whenever the packet ends
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_dcnt  <= 2'd0;
      r_shift <= 6'd0;
    end else if (!axiiv || r_state == S_WAIT_IDLE) begin
      r_dcnt  <= 2'd0;
    end else begin
      r_dcnt  <= r_dcnt + 2'd1;
      r_shift <= {r_shift[3:0], axiid};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_WAIT_IDLE;
    else       r_state <= w_state_n;
  end

  // Next-state and per-cycle control decode
  always_comb begin
    w_state_n   = r_state;
    w_write     = 1'b0;
    w_hdr_bad   = 1'b0;
    w_load_base = 1'b0;
    unique case (r_state)
      S_WAIT_IDLE: begin
        if (!axiiv) w_state_n = S_IDLE;
      end
      S_IDLE: begin
        if (axiiv) w_state_n = S_HDR_HI;
      end
      S_HDR_HI: begin
        if (!axiiv) begin
          w_state_n = S_IDLE;
          w_hdr_bad = 1'b1;
        end else if (w_byte_done) begin
          w_state_n = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (!axiiv) begin
          w_state_n = S_IDLE;
          w_hdr_bad = 1'b1;
        end else if (w_byte_done) begin
          if (w_row < LP_ROWS) begin
            w_load_base = 1'b1;
            w_state_n   = S_PIXELS;
          end else begin
            w_hdr_bad = 1'b1;
            w_state_n = S_DRAIN;
          end
        end
      end
      S_PIXELS: begin
        if (!axiiv) begin
          w_state_n = S_IDLE;
        end else if (w_byte_done) begin
          w_write = 1'b1;
          if (r_col == LP_COL_LAST) w_state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!axiiv) w_state_n = S_IDLE;
      end
      default: w_state_n = S_WAIT_IDLE;
    endcase
  end

  // Header latch, row base and column counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_row_hi <= 8'd0;
      r_base   <= '0;
      r_col    <= '0;
    end else begin
      if (r_state == S_HDR_HI && w_byte_done) r_row_hi <= w_byte;
      if (w_load_base) begin
        r_base <= w_row_base;
        r_col  <= '0;
      end else if (w_write) begin
        r_col  <= r_col + ADDR_WIDTH'(1);
      end
    end
  end

  // Registered write port and end-of-frame flag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pv   <= 1'b0;
      r_fd   <= 1'b0;
      r_addr <= '0;
      r_pix  <= 8'd0;
    end else begin
      r_pv <= w_write;
      r_fd <= w_write && (w_addr == LP_ADDR_LAST);
      if (w_write) begin
        r_addr <= w_addr;
        r_pix  <= w_byte;
      end
    end
  end

  // Saturating packet/header counters, independent of the FSM
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_good <= 16'd0;
      r_bad  <= 16'd0;
      r_bhdr <= 16'd0;
    end else begin
      if (crc_done && crc_kill && r_bad != LP_SAT)
        r_bad <= r_bad + 16'd1;
      if (crc_done && !crc_kill && r_good != LP_SAT)
        r_good <= r_good + 16'd1;
      if (w_hdr_bad && r_bhdr != LP_SAT)
        r_bhdr <= r_bhdr + 16'd1;
    end
  end

  assign pixel_addr_out  = r_addr;
  assign pixel_out       = r_pix;
  assign pixel_valid_out = r_pv;
  assign frame_done_out  = r_fd;
  assign good_pkt_count  = r_good;
  assign bad_pkt_count   = r_bad;
  assign bad_hdr_count   = r_bhdr;

endmodule

// File: tb/tb_eth_pixel_write_ctrl.sv
// Bench for eth_pixel_write_ctrl: directed packets with a write scoreboard.
// Expected writes carry the cycle on which they must appear.
module tb_eth_pixel_write_ctrl;

  localparam int H = 320;
  localparam int V = 240;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        axiiv = 1'b0;
  logic [1:0]  axiid = 2'd0;
  logic        crc_done = 1'b0;
  logic        crc_kill = 1'b0;
  logic [16:0] addr;
  logic [7:0]  pix;
  logic        pv;
  logic        fd;
  logic [15:0] good;
  logic [15:0] bad;
  logic [15:0] badh;

  eth_pixel_write_ctrl dut (
    .clk             (clk),
    .rstn            (rstn),
    .axiiv           (axiiv),
    .axiid           (axiid),
    .crc_done        (crc_done),
    .crc_kill        (crc_kill),
    .pixel_addr_out  (addr),
    .pixel_out       (pix),
    .pixel_valid_out (pv),
    .frame_done_out  (fd),
    .good_pkt_count  (good),
    .bad_pkt_count   (bad),
    .bad_hdr_count   (badh)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [16:0] a;
    logic [7:0]  d;
    logic        f;
    logic [31:0] c;
  } exp_t;

  exp_t        q[$];
  exp_t        e_mon;
  logic [7:0]  pl[$];
  logic [31:0] ncyc = 0;
  int          compared = 0;
  int          mism = 0;
  int          nwrites = 0;
  int          exp_writes = 0;
  int          nfd = 0;
  int          exp_good = 0;
  int          exp_bad = 0;
  int          exp_bh = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every write
  always @(negedge clk) begin
    if (mon_en) begin
      if (fd === 1'b1) nfd++;
      if (pv === 1'b1) begin
        nwrites++;
        compared++;
        assert (q.size() != 0) else begin
          mism++;
          $error("FAIL unexpected_write addr=%0d data=%0h expected=none",
                 addr, pix);
        end
        if (q.size() != 0) begin
          e_mon = q.pop_front();
          check("wr_addr", 32'(addr), 32'(e_mon.a));
          check("wr_data", 32'(pix), 32'(e_mon.d));
          check("wr_fdone", 32'(fd), 32'(e_mon.f));
          check("wr_cycle", ncyc, e_mon.c);
        end
      end else begin
        check("fdone_idle", 32'(fd), 32'd0);
      end
    end
  end

  task automatic dib(input logic [1:0] d);
    @(negedge clk);
    axiiv = 1'b1;
    axiid = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      axiiv = 1'b0;
      axiid = 2'd0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit wr,
                           input logic [16:0] a);
    for (int k = 3; k >= 0; k--) begin
      @(negedge clk);
      axiiv = 1'b1;
      axiid = b[2*k +: 2];
      if (k == 0 && wr) begin
        q.push_back('{a: a, d: b,
                      f: (a == 17'(H * V - 1)), c: ncyc + 1});
        exp_writes++;
      end
    end
  endtask

  task automatic send_pkt(input logic [15:0] row);
    bit ok;
    ok = (int'(row) < V);
    send_byte(row[15:8], 1'b0, 17'd0);
    send_byte(row[7:0], 1'b0, 17'd0);
    if (!ok) exp_bh++;
    for (int i = 0; i < pl.size(); i++)
      send_byte(pl[i], ok && (i < H), 17'(int'(row) * H + i));
    idle(3);
  endtask

  task automatic crc_pulse(input logic kill);
    @(negedge clk);
    crc_done = 1'b1;
    crc_kill = kill;
    @(negedge clk);
    crc_done = 1'b0;
    crc_kill = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_good"}, 32'(good), 32'(exp_good));
    check({tag, "_bad"}, 32'(bad), 32'(exp_bad));
    check({tag, "_badhdr"}, 32'(badh), 32'(exp_bh));
    check({tag, "_qempty"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    mon_en = 1'b1;
    check("rst_valid", 32'(pv), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_pix", 32'(pix), 32'd0);
    check_counters("rst");
    idle(2);

    // 1: single row, two pixels
    pl = {};
    pl.push_back(8'hA5);
    pl.push_back(8'h3C);
    send_pkt(16'h0002);
    check_counters("t1");

    // 2: last row, 322 bytes; frame_done once
    pl = {};
    for (int i = 0; i < 322; i++) pl.push_back(8'(i * 37 + 5));
    send_pkt(16'h00EF);
    check("t2_fdone_count", 32'(nfd), 32'd1);
    check_counters("t2");

    // 3: bad row header, then a 6-dibit packet
    pl = {};
    for (int i = 0; i < 10; i++) pl.push_back(8'(i + 1));
    send_pkt(16'h00F0);
    for (int i = 0; i < 6; i++) dib(2'(i));
    exp_bh++;
    idle(3);
    check_counters("t3");

    // 4: partial trailing byte is discarded
    send_byte(8'h00, 1'b0, 17'd0);
    send_byte(8'h00, 1'b0, 17'd0);
    send_byte(8'h11, 1'b1, 17'd0);
    dib(2'b11);
    dib(2'b01);
    idle(3);
    pl = {};
    pl.push_back(8'h5A);
    pl.push_back(8'h6B);
    send_pkt(16'h0003);
    check_counters("t4");

    // 5: CRC verdicts, one coinciding with a pixel write
    crc_pulse(1'b0);
    crc_pulse(1'b0);
    exp_good = 2;
    pl = {};
    pl.push_back(8'h99);
    fork
      send_pkt(16'h0004);
      begin
        repeat (11) @(negedge clk);
        crc_pulse(1'b1);
      end
    join
    exp_bad = 1;
    check_counters("t5");

    // 5b: saturation of the bad-packet counter
    @(negedge clk);
    crc_done = 1'b1;
    crc_kill = 1'b1;
    repeat (65540) @(negedge clk);
    crc_done = 1'b0;
    crc_kill = 1'b0;
    @(negedge clk);
    exp_bad = 65535;
    check_counters("t5_sat");
    crc_pulse(1'b1);
    crc_pulse(1'b0);
    exp_good = 3;
    check_counters("t5_hold");

    // 6: reset while writing pixels
    send_byte(8'h00, 1'b0, 17'd0);
    send_byte(8'h05, 1'b0, 17'd0);
    send_byte(8'h01, 1'b1, 17'd1600);
    send_byte(8'h02, 1'b1, 17'd1601);
    @(negedge clk);
    rstn = 1'b0;
    axiiv = 1'b1;
    axiid = 2'b10;
    @(negedge clk);
    rstn = 1'b1;
    axiid = 2'b01;
    exp_good = 0;
    exp_bad = 0;
    exp_bh = 0;
    check("t6_rst_valid", 32'(pv), 32'd0);
    check("t6_rst_addr", 32'(addr), 32'd0);
    check("t6_rst_pix", 32'(pix), 32'd0);
    check("t6_rst_fdone", 32'(fd), 32'd0);
    check_counters("t6_rst");
    for (int i = 0; i < 40; i++) dib(2'(i * 3 + 1));
    idle(3);
    pl = {};
    pl.push_back(8'h77);
    send_pkt(16'h0001);
    check_counters("t6");
    check("total_writes", 32'(nwrites), 32'(exp_writes));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule
